// File: rtl/shiftreg_deser.sv
// Serial-in/parallel-out receiver, MSB first, with a valid/ready holding register for each word.
// Define DESER_PARITY_EN to expect a trailing even-parity bit after every N data bits.
module shiftreg_deser #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         start,
    output logic [N-1:0] q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         busy,
    output logic         overrun,
    output logic         frame_err,
    output logic         parity_err
);

`ifdef DESER_PARITY_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif
    // The shifter only keeps the bits received before the final one of a word.
    localparam int SRW = L - 1;
    localparam int CW  = (L > 2) ? $clog2(L) : 1;
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    logic [SRW-1:0] r_sr;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_q;
    logic           r_q_valid;
    logic           r_overrun;
    logic           r_frame_err;

    logic [N-1:0]   w_word;
    logic           w_complete;
    logic           w_accept;
    logic [CW-1:0]  w_cnt_next;

    assign w_complete = sin_valid & ~start & (r_cnt == LAST);

`ifdef DESER_PARITY_EN
    logic r_parity_err;

    function automatic logic even_parity_ok(input logic [N-1:0] data, input logic par);
        return ~(^data ^ par);
    endfunction

    assign w_word     = r_sr;
    assign w_accept   = w_complete & even_parity_ok(r_sr, sin);
    assign parity_err = r_parity_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_complete & ~even_parity_ok(r_sr, sin);
        end
    end
`else
    assign w_word     = {r_sr, sin};
    assign w_accept   = w_complete;
    assign parity_err = 1'b0;
`endif

    always_comb begin
        w_cnt_next = r_cnt;
        if (sin_valid) begin
            if (start) begin
                w_cnt_next = CW'(1);
            end else if (r_cnt == LAST) begin
                w_cnt_next = '0;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
            end
        end
    end

    // Receive side: shifter, bit counter and framing pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= sin_valid & start & (r_cnt != '0);
            r_cnt       <= w_cnt_next;
            if (sin_valid) begin
                r_sr <= SRW'({r_sr, sin});
            end
        end
    end

    // Holding register: a consume and a reload may land on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_accept & r_q_valid & ~q_ready;
            if (w_accept) begin
                if (!r_q_valid || q_ready) begin
                    r_q       <= w_word;
                    r_q_valid <= 1'b1;
                end
            end else if (r_q_valid && q_ready) begin
                r_q_valid <= 1'b0;
            end
        end
    end

    assign q         = r_q;
    assign q_valid   = r_q_valid;
    assign busy      = (r_cnt != '0);
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_shiftreg_deser.sv
// Bench for shiftreg_deser (N=8): vector table, directed corner sequences and random traffic
// against a bit-queue reference model. Follows DESER_PARITY_EN the same way as the design.
module tb_shiftreg_deser;

    localparam int N = 8;
`ifdef DESER_PARITY_EN
    localparam int L = N + 1;
`else
    localparam int L = N;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         sin, sin_valid, start, q_ready;
    logic [N-1:0] q;
    logic         q_valid, busy, overrun, frame_err, parity_err;

    int tests = 0;
    int fails = 0;

    // Reference state: bits of the word in progress, plus the holding register.
    bit           m_bits[$];
    logic [N-1:0] m_q;
    logic         m_qv, m_ovr, m_frm, m_perr;

    typedef struct {
        logic         sin, sv, st, rdy;
        logic [N-1:0] exp_q;
        logic         exp_qv, exp_busy;
    } vec_t;

    shiftreg_deser #(.N(N)) dut (
        .clk(clk), .reset_n(reset_n), .sin(sin), .sin_valid(sin_valid), .start(start),
        .q(q), .q_valid(q_valid), .q_ready(q_ready), .busy(busy), .overrun(overrun),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_q = '0; m_qv = 0; m_ovr = 0; m_frm = 0; m_perr = 0;
    endtask

    task automatic model_edge(input logic b, input logic sv, input logic st, input logic rdy);
        bit           done = 0;
        bit           par_ok = 1;
        logic [N-1:0] word = '0;
        m_ovr = 0; m_frm = 0; m_perr = 0;
        if (sv) begin
            if (st) begin
                if (m_bits.size() != 0) m_frm = 1;
                m_bits.delete();
            end
            m_bits.push_back(b);
            if (m_bits.size() == L) begin
                int ones = 0;
                done = 1;
                for (int i = 0; i < N; i++) word = {word[N-2:0], m_bits[i]};
                for (int i = 0; i < L; i++) ones += m_bits[i];
                par_ok = (L == N) || (ones % 2 == 0);
                m_bits.delete();
            end
        end
        if (m_qv && rdy) m_qv = 0;
        if (done && !par_ok) begin
            m_perr = 1;
        end else if (done) begin
            if (m_qv) begin
                m_ovr = 1;
            end else begin
                m_q = word;
                m_qv = 1;
            end
        end
    endtask

    task automatic model_cmp();
        chk("q", q, m_q);
        chk("q_valid", q_valid, m_qv);
        chk("busy", busy, m_bits.size() != 0);
        chk("overrun", overrun, m_ovr);
        chk("frame_err", frame_err, m_frm);
        chk("parity_err", parity_err, m_perr);
    endtask

    task automatic tick(input logic b, input logic sv, input logic st, input logic rdy);
        sin = b; sin_valid = sv; start = st; q_ready = rdy;
        @(posedge clk);
        model_edge(b, sv, st, rdy);
        #1;
        model_cmp();
    endtask

    // Sends one word MSB first (plus parity bit when enabled), start on the first bit,
    // random idle gaps of up to gapmax cycles before each bit after the first.
    task automatic send_word(input logic [N-1:0] w, input int gapmax, input logic rdy_bits,
                             input logic rdy_last, input logic flip_par, input logic exp_frm);
        logic [L-1:0] bits;
`ifdef DESER_PARITY_EN
        bits = {w, ^w ^ flip_par};
`else
        bits = w;
        if (flip_par) bits = w;
`endif
        for (int i = L - 1; i >= 0; i--) begin
            if (i != L - 1) begin
                int g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
                for (int k = 0; k < g; k++) tick(1'b0, 1'b0, 1'b0, rdy_bits);
            end
            tick(bits[i], 1'b1, (i == L - 1), (i == 0) ? rdy_last : rdy_bits);
            if (i == L - 1) chk("frame_err_first_bit", frame_err, exp_frm);
        end
    endtask

    initial begin
        vec_t vt[9];
        logic [7:0] a5;
        sin = 0; sin_valid = 0; start = 0; q_ready = 0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", q, 8'h00);
        chk("reset_q_valid", q_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_pulses", {overrun, frame_err, parity_err}, 3'b000);
        reset_n = 1'b1;

`ifdef DESER_PARITY_EN
        send_word(8'hA5, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("par_good_q", q, 8'hA5);
        chk("par_good_qv", q_valid, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'hA5, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("par_bad_perr", parity_err, 1'b1);
        chk("par_bad_qv", q_valid, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("par_bad_perr_clear", parity_err, 1'b0);
`else
        // 0xA5 MSB first, start on bit 0, word visible right after the 8th edge.
        a5 = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            vt[i].sin = a5[7-i]; vt[i].sv = 1; vt[i].st = (i == 0); vt[i].rdy = 0;
            vt[i].exp_q = (i == 7) ? 8'hA5 : 8'h00;
            vt[i].exp_qv = (i == 7);
            vt[i].exp_busy = (i != 7);
        end
        vt[8] = '{sin: 0, sv: 0, st: 0, rdy: 1, exp_q: 8'hA5, exp_qv: 0, exp_busy: 0};
        for (int i = 0; i < 9; i++) begin
            tick(vt[i].sin, vt[i].sv, vt[i].st, vt[i].rdy);
            chk($sformatf("vec%0d_q", i), q, vt[i].exp_q);
            chk($sformatf("vec%0d_qv", i), q_valid, vt[i].exp_qv);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
        end
`endif

        // Gapped word with consumer always ready.
        send_word(8'h3C, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("gap_q", q, 8'h3C);
        chk("gap_qv", q_valid, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("gap_qv_one_cycle", q_valid, 1'b0);

        // Overrun: second word dropped while first still held.
        send_word(8'h11, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulse", overrun, 1'b1);
        chk("ovr_q_held", q, 8'h11);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_pulse_once", overrun, 1'b0);

        // Accept and reload on the same edge.
        send_word(8'h22, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reload_q", q, 8'h22);
        chk("reload_qv", q_valid, 1'b1);
        chk("reload_no_ovr", overrun, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);

        // Restart mid-word.
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
        send_word(8'h5A, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("frame_q", q, 8'h5A);
        chk("frame_qv", q_valid, 1'b1);

        // Async reset mid-word.
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_q", q, 8'h00);
        chk("arst_qv", q_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_cmp();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
